// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default sizes, address-width function and
// parameter legality checks used at elaboration time.
package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  // Ceiling log2 for constant sizing; clog2(16) = 4.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Depth must be a power of two (pointer wrap relies on it) and the
  // almost-empty level must sit strictly below the almost-full level.
  function automatic bit params_legal(input int width, input int depth,
                                      input int ae_level, input int af_level);
    return (width >= 1) && (depth >= 4) && is_pow2(depth) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one registered
// read port. No reset, so it maps onto block RAM and can be shared with
// clock-crossing FIFOs later.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store data at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: capture the addressed word only on an enabled read, so the
  // output holds its last value between reads.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and a read-data valid strobe.
// Handshake: a write is taken when write is high and the FIFO was not full
// before the edge (or a read is taken on the same edge); a read is taken
// when read is high and the FIFO was not empty before the edge. Rejected
// requests raise overflow/underflow for exactly the following cycle.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [WIDTH-1:0]        din,
  input  logic                    read,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  if (!params_legal(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  // Pointers carry one extra MSB so full and empty are distinguishable;
  // they wrap naturally modulo 2^(AW+1).
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, empty_q, af_q, ae_q;
  logic        dvalid_q, ovf_q, udf_q;
  logic        dout_live_q;
  logic        wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_rdata;

  // Acceptance and next-state pointer/count, decided from pre-edge flags.
  always_comb begin
    wr_ok   = write & (~full_q | read);
    rd_ok   = read & ~empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count, flag and pulse registers; flags derive from next count
  // so they change in the same cycle as count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      dvalid_q    <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      dout_live_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      dvalid_q <= rd_ok;
      ovf_q    <= write & ~wr_ok;
      udf_q    <= read & ~rd_ok;
      if (rd_ok) dout_live_q <= 1'b1;
    end
  end

  // The RAM read register has no reset; dout is forced to zero until the
  // first accepted read after reset, which gives the reset value of dout
  // without clearing storage.
  fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok & ~reset),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (din),
    .re_i    (rd_ok & ~reset),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign dout         = dout_live_q ? ram_rdata : '0;
  assign dout_valid   = dvalid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed phases plus random traffic, every
// output checked after each edge against a queue-based model.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             write;
  logic [WIDTH-1:0] din;
  logic             read;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_valid;
  logic             exp_ovf;
  logic             exp_udf;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .din          (din),
    .read         (read),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  // One clock edge of FIFO behaviour, stated with queue operations.
  task automatic model_edge(input bit w, input logic [WIDTH-1:0] d, input bit r);
    bit was_full, was_empty, take_w, take_r;
    if (reset) begin
      model_reset();
      return;
    end
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    take_w    = w && (!was_full || r);
    take_r    = r && !was_empty;
    exp_ovf   = w && !take_w;
    exp_udf   = r && !take_r;
    exp_valid = take_r;
    if (take_r) exp_dout = exp_q.pop_front();
    if (take_w) exp_q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    int c;
    c = exp_q.size();
    chk({tag, ".count"},        32'(count),        32'(c));
    chk({tag, ".full"},         32'(full),         32'(c == DEPTH));
    chk({tag, ".empty"},        32'(empty),        32'(c == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(c >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= AE));
    chk({tag, ".dout"},         32'(dout),         32'(exp_dout));
    chk({tag, ".dout_valid"},   32'(dout_valid),   32'(exp_valid));
    chk({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(exp_udf));
  endtask

  // Driver: apply one request set across one edge, then check everything.
  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input string tag);
    write = w;
    din   = d;
    read  = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    check_all(tag);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    write = 1'b0;
    read  = 1'b0;
    din   = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);

    // Overflow while full, pulse must clear next cycle
    step(1'b1, 8'hAA, 1'b0, "overflow");
    step(1'b0, 8'h00, 1'b0, "overflow_clear");

    // Drain in order, never seeing 0xAA
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, "drain");
      chk("drain_data", 32'(dout), 32'(i));
    end

    // Underflow from empty: dout holds 0x10
    step(1'b0, 8'h00, 1'b1, "underflow");
    chk("underflow_hold", 32'(dout), 32'h10);

    // Refill with random data, then read+write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0, "refill");
    step(1'b1, 8'h55, 1'b1, "full_rw");
    chk("full_rw_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain2");

    // Read+write while empty: no fall-through
    step(1'b1, 8'h77, 1'b1, "empty_rw");
    chk("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, "read_77");
    chk("read_77_data", 32'(dout), 32'h77);

    // Steady state at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, "wrap_prime");
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, "wrap");
    chk("wrap_count", 32'(count), 32'd3);

    // Random traffic with varying read/write bias
    for (int i = 0; i < 400; i++) begin
      bit w, r;
      if (i < 130) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else if (i < 260) begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end else begin
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      step(w, 8'($urandom), r, "random");
    end

    // Bring occupancy to 9, then reset between edges
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, "pre_drain");
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, "prefill9");
    chk("prefill9_count", 32'(count), 32'd9);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");

    // Requests during reset are ignored
    step(1'b1, 8'hEE, 1'b1, "reset_cycle");
    reset = 1'b0;

    // First read after reset underflows
    step(1'b0, 8'h00, 1'b1, "post_reset_read");
    chk("post_reset_udf", 32'(underflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
